rc_channel_sequencer: RTL and testbench

Schedules the per-channel receiver conditioning controllers (throttle, yaw, roll, pitch), which all use a start/active/complete handshake. On each receiver frame it starts the controllers one at a time in fixed order and watchdogs each one. It then publishes one coherent value bundle to the downstream attitude/body-frame stage, and rate-limits publishes to a minimum period. It sits between the receiver capture logic and the channel controllers.

---
 rtl/rc_channel_sequencer_pkg.sv | 46 ++++
 rtl/rc_channel_sequencer_watchdog.sv | 42 ++++
 rtl/rc_channel_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rc_channel_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_channel_sequencer_pkg.sv
// Shared constants and types for the receiver channel sequencer.
// Carries the legacy defines (REC_VAL_BIT_WIDTH, TRUE/FALSE, BYTE_ALL_ZERO)
// so files that predate the package keep compiling unchanged.
// Optional feature macro used by the top: RC_SEQ_FAILSAFE_EN.

`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef BYTE_ALL_ZERO
`define BYTE_ALL_ZERO 8'h00
`endif

package rc_channel_sequencer_pkg;

    localparam int REC_VAL_W        = `REC_VAL_BIT_WIDTH;

    // Default sequencing parameters (1 MHz us_clk).
    localparam int RC_NUM_CH        = 4;
    localparam int RC_TIMEOUT_US    = 64;
    localparam int RC_MIN_PERIOD_US = 2500;

    // Channel indices in sequencing order.
    localparam int RC_CH_THROTTLE   = 0;
    localparam int RC_CH_YAW        = 1;
    localparam int RC_CH_ROLL       = 2;
    localparam int RC_CH_PITCH      = 3;

    // Stick-centre value published for a faulted non-throttle channel.
    localparam logic [REC_VAL_W-1:0] RC_CENTER_VALUE = REC_VAL_W'(128);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_NEXT      = 3'd3,
        ST_PUBLISH   = 3'd4,
        ST_HOLDOFF   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/rc_channel_sequencer_watchdog.sv
// rc_seq_watchdog: loadable down-counter with an expired flag.
// Load has priority over decrement; the count saturates at zero and never
// wraps. Used for both the per-channel timeout and the publish holdoff.

module rc_seq_watchdog #(
    parameter int W = 8
) (
    input  logic         us_clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload wins, otherwise step down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == '0);

endmodule

// File: rtl/rc_channel_sequencer.sv
// rc_channel_sequencer: on each receiver frame, starts the channel
// conditioning controllers one at a time (throttle, yaw, roll, pitch),
// watchdogs each, then publishes one coherent bundle and holds off further
// publishes for a minimum period.
// Optional feature: RC_SEQ_FAILSAFE_EN forces faulted channels to safe
// values at publish (throttle -> 0, others -> centre).
//
// Handshake with each controller: ch_start_o[i] is raised (registered) and
// held until ch_active_i[i] is seen or the watchdog is about to expire;
// ch_complete_i[i] is a single-cycle strobe that qualifies the matching
// ch_value_in_i slice. Inputs for non-selected channels are ignored.
// values_valid_o is a one-cycle pulse coincident with the new values_out_o.

module rc_channel_sequencer
    import rc_channel_sequencer_pkg::*;
#(
    parameter int NUM_CH        = RC_NUM_CH,
    parameter int TIMEOUT_US    = RC_TIMEOUT_US,
    parameter int MIN_PERIOD_US = RC_MIN_PERIOD_US
) (
    input  logic                          us_clk,
    input  logic                          resetn,
    input  logic                          frame_valid_i,
    output logic [NUM_CH-1:0]             ch_start_o,
    input  logic [NUM_CH-1:0]             ch_active_i,
    input  logic [NUM_CH-1:0]             ch_complete_i,
    input  logic [NUM_CH*REC_VAL_W-1:0]   ch_value_in_i,
    output logic [NUM_CH*REC_VAL_W-1:0]   values_out_o,
    output logic                          values_valid_o,
    output logic                          busy_o,
    output logic [NUM_CH-1:0]             ch_fault_o,
    output logic                          overrun_o,
    output logic [2:0]                    state_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_US + 1);
    localparam int HO_W  = $clog2(MIN_PERIOD_US + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef logic [NUM_CH-1:0][REC_VAL_W-1:0] bundle_t;

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] start_q, start_d;
    logic [NUM_CH-1:0] fault_q, fault_d;
    bundle_t           shadow_q, shadow_d;
    bundle_t           values_q, values_d;
    logic              vvalid_q, vvalid_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;

    logic              to_load, to_dec, to_expired;
    logic [TO_W-1:0]   to_count;
    logic              ho_load, ho_dec, ho_expired;
    logic [HO_W-1:0]   ho_count_unused;
    logic [REC_VAL_W-1:0] cur_val;

    assign cur_val = ch_value_in_i[int'(idx_q)*REC_VAL_W +: REC_VAL_W];

    rc_seq_watchdog #(.W(TO_W)) u_timeout (
        .us_clk     (us_clk),
        .resetn     (resetn),
        .load_i     (to_load),
        .load_val_i (TO_W'(TIMEOUT_US)),
        .dec_i      (to_dec),
        .count_o    (to_count),
        .expired_o  (to_expired)
    );

    rc_seq_watchdog #(.W(HO_W)) u_holdoff (
        .us_clk     (us_clk),
        .resetn     (resetn),
        .load_i     (ho_load),
        .load_val_i (HO_W'(MIN_PERIOD_US - 1)),
        .dec_i      (ho_dec),
        .count_o    (ho_count_unused),
        .expired_o  (ho_expired)
    );

    // Next-state, frame buffering and per-channel handshake decisions.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_d   = start_q;
        fault_d   = fault_q;
        shadow_d  = shadow_q;
        values_d  = values_q;
        vvalid_d  = 1'b0;
        pending_d = pending_q;
        overrun_d = overrun_q;
        to_load   = 1'b0;
        to_dec    = 1'b0;
        ho_load   = 1'b0;
        ho_dec    = 1'b0;

        // A frame outside IDLE is buffered one deep; a second one is lost.
        if (frame_valid_i && (state_q != ST_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A frame arriving on the exit cycle is consumed here too.
                if (frame_valid_i || pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    fault_d   = '0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                start_d        = '0;
                start_d[idx_q] = 1'b1;
                to_load        = 1'b1;
                state_d        = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                to_dec = 1'b1;
                // Drop start once the controller acknowledges, and before the
                // watchdog runs out so it is never held past the timeout.
                if (ch_active_i[idx_q] || (to_count <= TO_W'(1))) begin
                    start_d = '0;
                end
                if (ch_complete_i[idx_q]) begin
                    shadow_d[idx_q] = cur_val;
                    start_d         = '0;
                    state_d         = ST_NEXT;
                end else if (to_expired) begin
                    fault_d[idx_q] = 1'b1;
                    start_d        = '0;
                    state_d        = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_PUBLISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_START;
                end
            end

            ST_PUBLISH: begin
                values_d = shadow_q;
`ifdef RC_SEQ_FAILSAFE_EN
                if (|fault_q) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (fault_q[i]) begin
                            values_d[i] = (i == RC_CH_THROTTLE) ? '0 : RC_CENTER_VALUE;
                        end
                    end
                end
`endif
                vvalid_d = 1'b1;
                ho_load  = 1'b1;
                state_d  = ST_HOLDOFF;
            end

            ST_HOLDOFF: begin
                ho_dec = 1'b1;
                if (ho_expired) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                start_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence without publishing.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            start_q   <= '0;
            fault_q   <= '0;
            shadow_q  <= '0;
            values_q  <= '0;
            vvalid_q  <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            fault_q   <= fault_d;
            shadow_q  <= shadow_d;
            values_q  <= values_d;
            vvalid_q  <= vvalid_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign ch_start_o     = start_q;
    assign values_out_o   = values_q;
    assign values_valid_o = vvalid_q;
    assign ch_fault_o     = fault_q;
    assign overrun_o      = overrun_q;
    assign busy_o         = (state_q == ST_START) || (state_q == ST_WAIT_DONE) ||
                            (state_q == ST_NEXT)  || (state_q == ST_PUBLISH);
    assign state_o        = state_q;

endmodule

// File: tb/tb_rc_channel_sequencer.sv
// Testbench for rc_channel_sequencer: behavioural channel controllers,
// frame driver tasks, and a publish scoreboard fed by an expected queue.

module tb_rc_channel_sequencer;

    localparam int NUM_CH = 4;
    localparam int TO     = 64;
    localparam int MP     = 2500;
    localparam int LAT    = 7;                    // controller cycles -> 10 per channel
    localparam int SEQ_BUSY = NUM_CH * (LAT + 3) + 1;

    // ---------------- clock / reset ----------------
    logic us_clk = 1'b0;
    logic resetn = 1'b0;
    always #5 us_clk = ~us_clk;

    int cyc = 0;
    always @(posedge us_clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                frame_valid = 1'b0;
    logic [NUM_CH-1:0]   ch_start_o;
    logic [NUM_CH-1:0]   ch_active = '0;
    logic [NUM_CH-1:0]   ch_complete = '0;
    logic [NUM_CH*8-1:0] ch_value = {NUM_CH{8'hEE}};
    logic [NUM_CH*8-1:0] values_out_o;
    logic                values_valid_o;
    logic                busy_o;
    logic [NUM_CH-1:0]   ch_fault_o;
    logic                overrun_o;
    logic [2:0]          state_o;

    rc_channel_sequencer dut (
        .us_clk         (us_clk),
        .resetn         (resetn),
        .frame_valid_i  (frame_valid),
        .ch_start_o     (ch_start_o),
        .ch_active_i    (ch_active),
        .ch_complete_i  (ch_complete),
        .ch_value_in_i  (ch_value),
        .values_out_o   (values_out_o),
        .values_valid_o (values_valid_o),
        .busy_o         (busy_o),
        .ch_fault_o     (ch_fault_o),
        .overrun_o      (overrun_o),
        .state_o        (state_o)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [35:0] mk(input logic [3:0] f, input logic [7:0] v3,
                                       input logic [7:0] v2, input logic [7:0] v1,
                                       input logic [7:0] v0);
        return {f, v3, v2, v1, v0};
    endfunction

    // ---------------- controller models ----------------
    int         lat [NUM_CH];
    logic [7:0] val [NUM_CH];
    bit         silent [NUM_CH];

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            lat[i] = LAT; val[i] = 8'h00; silent[i] = 1'b0;
        end
        forever begin
            @(negedge us_clk);
            if (resetn && (ch_start_o != '0)) begin
                automatic int c = oh_idx(ch_start_o);
                if (!silent[c]) begin
                    ch_active[c] = 1'b1;
                    repeat (lat[c]) @(negedge us_clk);
                    ch_complete[c]     = 1'b1;
                    ch_value[c*8 +: 8] = val[c];
                    @(negedge us_clk);
                    ch_complete[c]     = 1'b0;
                    ch_active[c]       = 1'b0;
                    ch_value[c*8 +: 8] = 8'hEE;
                end else begin
                    for (int k = 0; k < 4 * TO && ch_start_o[c]; k++) @(negedge us_clk);
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [35:0]       exp_q[$];
    int                pub_cyc[$];
    int                pub_count = 0;
    int                busy_cnt = 0;
    int                start_log[$];
    int                overlap_cnt = 0;
    int                run_len = 0;
    int                max_run = 0;
    logic [NUM_CH-1:0] prev_start = '0;

    always @(negedge us_clk) begin
        if (resetn) begin
            if (values_valid_o) begin
                pub_count++;
                pub_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_publish", values_out_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    automatic logic [35:0] e = exp_q.pop_front();
                    check("publish_bundle", values_out_o, e[31:0]);
                    check("publish_fault", ch_fault_o, e[35:32]);
                end
            end
            if (busy_o) busy_cnt++;
            if ((ch_start_o != '0) && (ch_start_o != prev_start))
                start_log.push_back(oh_idx(ch_start_o));
            if ($countones(ch_start_o) > 1) overlap_cnt++;
            if ((ch_start_o != '0) && (ch_start_o == prev_start)) run_len++;
            else run_len = (ch_start_o != '0) ? 1 : 0;
            if (run_len > max_run) max_run = run_len;
            prev_start = ch_start_o;
        end else begin
            prev_start = '0;
            run_len    = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame();
        @(negedge us_clk);
        frame_valid = 1'b1;
        @(negedge us_clk);
        frame_valid = 1'b0;
    endtask

    task automatic wait_pubs(input int n, input int budget);
        for (int k = 0; k < budget && pub_count < n; k++) @(negedge us_clk);
        check("publish_arrived", (pub_count >= n), 1'b1);
    endtask

    task automatic set_vals(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
    endtask

    task automatic check_order();
        check("start_count", start_log.size(), NUM_CH);
        for (int i = 0; i < NUM_CH && i < start_log.size(); i++)
            check("start_order", start_log[i], i);
        start_log.delete();
        check("start_overlap", overlap_cnt, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ch_start", ch_start_o, 0);
        check("rst_values_out", values_out_o, 0);
        check("rst_values_valid", values_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ch_fault", ch_fault_o, 0);
        check("rst_overrun", overrun_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int spacing;

        repeat (3) @(negedge us_clk);
        check_reset_outputs();
        resetn = 1'b1;
        repeat (3) @(negedge us_clk);

        // Normal sequence: 50/120/130/140
        set_vals(8'd50, 8'd120, 8'd130, 8'd140);
        exp_q.push_back(mk(4'b0000, 8'd140, 8'd130, 8'd120, 8'd50));
        busy_cnt = 0;
        send_frame();
        wait_pubs(1, 300);
        repeat (2) @(negedge us_clk);
        check("busy_cycles_normal", busy_cnt, SEQ_BUSY);
        check("busy_low_holdoff", busy_o, 0);
        check_order();
        repeat (MP + 20) @(negedge us_clk);

        // Roll controller silent: fault on channel 2
        set_vals(8'd51, 8'd121, 8'd131, 8'd141);
        silent[2] = 1'b1;
        max_run = 0;
`ifdef RC_SEQ_FAILSAFE_EN
        exp_q.push_back(mk(4'b0100, 8'd141, 8'd128, 8'd121, 8'd51));
`else
        exp_q.push_back(mk(4'b0100, 8'd141, 8'd130, 8'd121, 8'd51));
`endif
        busy_cnt = 0;
        send_frame();
        wait_pubs(2, 400);
        repeat (2) @(negedge us_clk);
        check("busy_cycles_timeout_lo", (busy_cnt >= 3 * (LAT + 3) + TO + 3), 1'b1);
        check("busy_cycles_timeout_hi", (busy_cnt <= 3 * (LAT + 3) + TO + 5), 1'b1);
        check("start_max_run", (max_run <= TO), 1'b1);
        check_order();
        silent[2] = 1'b0;
        repeat (MP + 20) @(negedge us_clk);

        // Throttle controller silent
        set_vals(8'd52, 8'd122, 8'd132, 8'd142);
        silent[0] = 1'b1;
`ifdef RC_SEQ_FAILSAFE_EN
        exp_q.push_back(mk(4'b0001, 8'd142, 8'd132, 8'd122, 8'd0));
`else
        exp_q.push_back(mk(4'b0001, 8'd142, 8'd132, 8'd122, 8'd51));
`endif
        send_frame();
        wait_pubs(3, 400);
        check_order();
        silent[0] = 1'b0;
        repeat (MP + 20) @(negedge us_clk);

        // Rate limit: frames 100 cycles apart; second pends, third overruns
        set_vals(8'd60, 8'd61, 8'd62, 8'd63);
        exp_q.push_back(mk(4'b0000, 8'd63, 8'd62, 8'd61, 8'd60));
        exp_q.push_back(mk(4'b0000, 8'd73, 8'd72, 8'd71, 8'd70));
        base = pub_cyc.size();
        send_frame();
        repeat (98) @(negedge us_clk);
        check("busy_low_holdoff2", busy_o, 0);
        send_frame();
        repeat (98) @(negedge us_clk);
        check("overrun_before", overrun_o, 0);
        set_vals(8'd70, 8'd71, 8'd72, 8'd73);
        send_frame();
        @(negedge us_clk);
        check("overrun_set", overrun_o, 1);
        wait_pubs(5, 3000);
        start_log.delete();
        if (pub_cyc.size() >= base + 2) begin
            spacing = pub_cyc[base + 1] - pub_cyc[base];
            check("publish_spacing_min", (spacing >= MP + 1), 1'b1);
            check("publish_spacing", spacing, MP + 1 + SEQ_BUSY);
        end
        repeat (MP + 200) @(negedge us_clk);
        check("overrun_frame_dropped", pub_count, 5);
        check("overrun_sticky", overrun_o, 1);

        // Reset during WAIT_DONE on channel 1
        set_vals(8'd90, 8'd91, 8'd92, 8'd93);
        send_frame();
        for (int k = 0; k < 200 && !ch_start_o[1]; k++) @(negedge us_clk);
        check("reached_ch1", ch_start_o[1], 1);
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge us_clk);
        resetn = 1'b1;
        repeat (200) @(negedge us_clk);
        check("no_publish_after_reset", pub_count, 5);
        start_log.delete();

        // Fresh frame after reset
        set_vals(8'd100, 8'd101, 8'd102, 8'd103);
        exp_q.push_back(mk(4'b0000, 8'd103, 8'd102, 8'd101, 8'd100));
        send_frame();
        wait_pubs(6, 300);
        check_order();

        repeat (10) @(negedge us_clk);
        check("expected_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
